// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU commands, shifter types,
// status-flag bit positions and the multiplier sequencing states.
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MUL = 4'b1010;
    localparam logic [3:0] CMD_MLA = 4'b1011;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_RUN  = 2'd1,
        S_MUL_WAIT = 2'd2
    } exe_state_e;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BPC multiplier bits per cycle;
// keeps only the low DATA_W bits of (mcand * mplier + addend).
module exe_mul_iter #(
    parameter int DATA_W  = 32,
    parameter int MUL_BPC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              run,
    input  logic [DATA_W-1:0] mcand,
    input  logic [DATA_W-1:0] mplier,
    input  logic [DATA_W-1:0] addend,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    localparam int STEPS = DATA_W / MUL_BPC;
    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [DATA_W-1:0] partial, acc_sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BPC; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
        acc_sum  = acc_q + partial;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = mcand;
            mplier_d = mplier;
            acc_d    = addend;
            cnt_d    = '0;
        end else if (run) begin
            mcand_d  = mcand_q << MUL_BPC;
            mplier_d = mplier_q >> MUL_BPC;
            acc_d    = acc_sum;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // The final step's sum is exposed combinationally so the caller can
    // retire the result on the same edge that completes the last step.
    assign done   = run & (cnt_q == LAST);
    assign result = run ? acc_sum : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/exe_stage_mc.sv
// ARM execute stage: operand forwarding, Val2 shifter, single-cycle ALU,
// iterative MUL/MLA and a stallable, flushable EXE/MEM output slot.
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FWD_N   = 2,
    parameter int MUL_BPC = 1,
    parameter int DEST_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   exe_cmd,
    input  logic                         s_bit,
    input  logic                         mem_r_en,
    input  logic                         mem_w_en,
    input  logic                         wb_en,
    input  logic [DEST_W-1:0]            dest,
    input  logic [DATA_W-1:0]            pc,
    input  logic [DATA_W-1:0]            val_rn,
    input  logic [DATA_W-1:0]            val_rm,
    input  logic [DATA_W-1:0]            val_ra,
    input  logic                         imm,
    input  logic [11:0]                  shift_operand,
    input  logic [23:0]                  signed_imm_24,
    input  logic [3:0]                   sr_in,
    input  logic [$clog2(FWD_N+1)-1:0]   sel_src1,
    input  logic [$clog2(FWD_N+1)-1:0]   sel_src2,
    input  logic [FWD_N*DATA_W-1:0]      fwd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_alu_result,
    output logic [DATA_W-1:0]            out_val_rm,
    output logic [DATA_W-1:0]            out_br_addr,
    output logic [3:0]                   out_status,
    output logic                         out_status_we,
    output logic                         out_mem_r_en,
    output logic                         out_mem_w_en,
    output logic                         out_wb_en,
    output logic [DEST_W-1:0]            out_dest,
    output logic                         busy
);
    localparam int SEL_W = $clog2(FWD_N + 1);
    localparam int MSB   = DATA_W - 1;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rm;
        logic [DATA_W-1:0] br;
        logic [3:0]        status;
        logic              status_we;
        logic              mr;
        logic              mw;
        logic              wb;
        logic [DEST_W-1:0] dest;
    } slot_t;

    function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input logic [4:0] amt);
        int unsigned r;
        r = int'(amt) % DATA_W;
        return (x >> r) | (x << (DATA_W - r));
    endfunction

    logic [DATA_W-1:0] op1, rm_fwd, val2, alu_res, br_addr, mul_result, mul_addend;
    logic [DATA_W:0]   sum_ext;
    logic              alu_c, alu_v;
    logic              slot_free, accept, is_mul, mul_start, mul_run, mul_done;
    logic              out_valid_q, out_valid_d;
    exe_state_e        state_q, state_d;
    slot_t             slot_q, slot_d, hold_q, hold_d, new_slot, mul_slot;

    // A select beyond the last forwarding source reads as zero.
    always_comb begin
        op1    = (sel_src1 == '0) ? val_rn : '0;
        rm_fwd = (sel_src2 == '0) ? val_rm : '0;
        for (int k = 1; k <= FWD_N; k++) begin
            if (sel_src1 == SEL_W'(k)) op1    = fwd_data[(k-1)*DATA_W +: DATA_W];
            if (sel_src2 == SEL_W'(k)) rm_fwd = fwd_data[(k-1)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        val2 = '0;
        if (mem_r_en | mem_w_en) begin
            val2 = DATA_W'(shift_operand);
        end else if (imm) begin
            val2 = ror(DATA_W'(shift_operand[7:0]), {shift_operand[11:8], 1'b0});
        end else begin
            case (shift_operand[6:5])
                SH_LSL:  val2 = rm_fwd << shift_operand[11:7];
                SH_LSR:  val2 = rm_fwd >> shift_operand[11:7];
                SH_ASR:  val2 = $unsigned($signed(rm_fwd) >>> shift_operand[11:7]);
                default: val2 = ror(rm_fwd, shift_operand[11:7]);
            endcase
        end
    end

    // Subtracts use a + ~b + carry-in so C is ARM's "no borrow" flag.
    always_comb begin
        sum_ext = '0;
        alu_res = '0;
        alu_c   = sr_in[ST_C];
        alu_v   = sr_in[ST_V];
        case (exe_cmd)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_AND: alu_res = op1 & val2;
            CMD_ORR: alu_res = op1 | val2;
            CMD_EOR: alu_res = op1 ^ val2;
            CMD_ADD, CMD_ADC: begin
                sum_ext = {1'b0, op1} + {1'b0, val2}
                        + ((exe_cmd == CMD_ADC) ? {{DATA_W{1'b0}}, sr_in[ST_C]} : '0);
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[DATA_W];
                alu_v   = (op1[MSB] == val2[MSB]) && (alu_res[MSB] != op1[MSB]);
            end
            CMD_SUB, CMD_SBC: begin
                sum_ext = {1'b0, op1} + {1'b0, ~val2}
                        + ((exe_cmd == CMD_SUB) ? {{DATA_W{1'b0}}, 1'b1}
                                                : {{DATA_W{1'b0}}, sr_in[ST_C]});
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[DATA_W];
                alu_v   = (op1[MSB] != val2[MSB]) && (alu_res[MSB] != op1[MSB]);
            end
            default: alu_res = '0;
        endcase
    end

    assign br_addr    = pc + DATA_W'($signed(signed_imm_24));
    assign is_mul     = (exe_cmd == CMD_MUL) || (exe_cmd == CMD_MLA);
    assign mul_addend = (exe_cmd == CMD_MLA) ? val_ra : '0;
    assign slot_free  = ~out_valid_q | out_ready;
    assign in_ready   = (state_q == S_IDLE) & slot_free & ~rst & ~flush;
    assign accept     = in_valid & in_ready;
    assign mul_start  = accept & is_mul;
    assign mul_run    = (state_q == S_MUL_RUN);

    always_comb begin
        new_slot           = '0;
        new_slot.alu       = alu_res;
        new_slot.rm        = rm_fwd;
        new_slot.br        = br_addr;
        new_slot.status    = {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
        new_slot.status_we = s_bit & ~mem_r_en & ~mem_w_en;
        new_slot.mr        = mem_r_en;
        new_slot.mw        = mem_w_en;
        new_slot.wb        = wb_en;
        new_slot.dest      = dest;
        mul_slot              = hold_q;
        mul_slot.alu          = mul_result;
        mul_slot.status[ST_N] = mul_result[MSB];
        mul_slot.status[ST_Z] = (mul_result == '0);
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q & ~out_ready;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    // sr_in is parked in the status field; N/Z are overwritten on completion.
                    hold_d        = new_slot;
                    hold_d.status = sr_in;
                    state_d       = S_MUL_RUN;
                end else if (accept) begin
                    slot_d      = new_slot;
                    out_valid_d = 1'b1;
                end
            end
            S_MUL_RUN: begin
                if (mul_done) begin
                    if (slot_free) begin
                        slot_d      = mul_slot;
                        out_valid_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_MUL_WAIT;
                    end
                end
            end
            S_MUL_WAIT: begin
                if (slot_free) begin
                    slot_d      = mul_slot;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
        end
    end

    exe_mul_iter #(
        .DATA_W  (DATA_W),
        .MUL_BPC (MUL_BPC)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .run    (mul_run),
        .mcand  (op1),
        .mplier (rm_fwd),
        .addend (mul_addend),
        .done   (mul_done),
        .result (mul_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_alu_result = slot_q.alu;
    assign out_val_rm     = slot_q.rm;
    assign out_br_addr    = slot_q.br;
    assign out_status     = slot_q.status;
    assign out_status_we  = slot_q.status_we;
    assign out_mem_r_en   = slot_q.mr;
    assign out_mem_w_en   = slot_q.mw;
    assign out_wb_en      = slot_q.wb;
    assign out_dest       = slot_q.dest;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc (DATA_W=32, FWD_N=2, MUL_BPC=1).
module tb_exe_stage_mc;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, s_bit, mem_r_en, mem_w_en, wb_en, imm;
    logic [3:0]  exe_cmd, dest, sr_in, out_status, out_dest;
    logic [31:0] pc, val_rn, val_rm, val_ra;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [1:0]  sel_src1, sel_src2;
    logic [63:0] fwd_data;
    logic        out_valid, out_ready, out_status_we, out_mem_r_en, out_mem_w_en, out_wb_en, busy;
    logic [31:0] out_alu_result, out_val_rm, out_br_addr;
    int          total = 0;
    int          bad = 0;

    exe_stage_mc #(.DATA_W(32), .FWD_N(2), .MUL_BPC(1), .DEST_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .s_bit(s_bit), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_en(wb_en), .dest(dest), .pc(pc), .val_rn(val_rn), .val_rm(val_rm),
        .val_ra(val_ra), .imm(imm), .shift_operand(shift_operand),
        .signed_imm_24(signed_imm_24), .sr_in(sr_in), .sel_src1(sel_src1),
        .sel_src2(sel_src2), .fwd_data(fwd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_alu_result(out_alu_result), .out_val_rm(out_val_rm),
        .out_br_addr(out_br_addr), .out_status(out_status), .out_status_we(out_status_we),
        .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en), .out_wb_en(out_wb_en),
        .out_dest(out_dest), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = 0; exe_cmd = 4'b0000; s_bit = 0; mem_r_en = 0; mem_w_en = 0;
        wb_en = 0; dest = 0; pc = 0; val_rn = 0; val_rm = 0; val_ra = 0; imm = 0;
        shift_operand = 0; signed_imm_24 = 0; sr_in = 0; sel_src1 = 0; sel_src2 = 0;
        fwd_data = 0; out_ready = 1;
    endtask

    task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                          input logic i, input logic [11:0] sh);
        exe_cmd = cmd; val_rn = rn; val_rm = rm; imm = i; shift_operand = sh; in_valid = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready act=%b exp=0", in_ready); end
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid act=%b exp=0", out_valid); end
        total++; if ({out_alu_result, out_br_addr, out_status, out_dest} !== '0) begin
            bad++; $display("FAIL reset_data act=%h exp=0", {out_alu_result, out_br_addr, out_status, out_dest}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy act=%b exp=0", busy); end
        rst = 0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready act=%b exp=1", in_ready); end
    endtask

    task automatic test_alu();
        set_op(4'b0010, 32'd5, 32'd0, 1'b1, 12'h003);
        step();
        total++; if (out_valid !== 1'b1 || out_alu_result !== 32'd8 || out_status !== 4'b0000) begin
            bad++; $display("FAIL add_imm act=%b/%h/%b exp=1/8/0000", out_valid, out_alu_result, out_status); end
        set_op(4'b0100, 32'd3, 32'd0, 1'b1, 12'h003); s_bit = 1;
        step();
        total++; if (out_alu_result !== 32'd0 || out_status !== 4'b0110 || out_status_we !== 1'b1) begin
            bad++; $display("FAIL sub_flags act=%h/%b/%b exp=0/0110/1", out_alu_result, out_status, out_status_we); end
        s_bit = 0;
        set_op(4'b0010, 32'h7FFF_FFFF, 32'd0, 1'b1, 12'h001);
        step();
        total++; if (out_alu_result !== 32'h8000_0000 || out_status !== 4'b1001) begin
            bad++; $display("FAIL add_ovf act=%h/%b exp=80000000/1001", out_alu_result, out_status); end
        set_op(4'b0011, 32'd1, 32'd0, 1'b1, 12'h001); sr_in = 4'b0010;
        step();
        total++; if (out_alu_result !== 32'd3 || out_status !== 4'b0000) begin
            bad++; $display("FAIL adc act=%h/%b exp=3/0000", out_alu_result, out_status); end
        set_op(4'b0101, 32'd5, 32'd0, 1'b1, 12'h003); sr_in = 4'b0000;
        step();
        total++; if (out_alu_result !== 32'd1 || out_status !== 4'b0010) begin
            bad++; $display("FAIL sbc act=%h/%b exp=1/0010", out_alu_result, out_status); end
        set_op(4'b0110, 32'h0000_00F0, 32'd0, 1'b1, 12'h0FF); sr_in = 4'b0011;
        step();
        total++; if (out_alu_result !== 32'h0000_00F0 || out_status !== 4'b0011) begin
            bad++; $display("FAIL and_keep_cv act=%h/%b exp=000000f0/0011", out_alu_result, out_status); end
        set_op(4'b0001, 32'd0, 32'd0, 1'b1, 12'h1FF);
        step();
        total++; if (out_alu_result !== 32'hC000_003F || out_status !== 4'b1011) begin
            bad++; $display("FAIL mov_rot_imm act=%h/%b exp=c000003f/1011", out_alu_result, out_status); end
        set_op(4'b1001, 32'd0, 32'h8000_0000, 1'b0, 12'h240); sr_in = 4'b0000;
        step();
        total++; if (out_alu_result !== 32'h07FF_FFFF) begin
            bad++; $display("FAIL mvn_asr act=%h exp=07ffffff", out_alu_result); end
        set_op(4'b0010, 32'd0, 32'd1, 1'b0, 12'h200);
        step();
        total++; if (out_alu_result !== 32'd16) begin
            bad++; $display("FAIL add_lsl act=%h exp=10", out_alu_result); end
        set_op(4'b0010, 32'd1, 32'd0, 1'b0, 12'hFFF);
        mem_r_en = 1; s_bit = 1; wb_en = 1; dest = 4'hA; pc = 32'h100; signed_imm_24 = 24'hFFFFFC;
        step();
        total++; if (out_alu_result !== 32'h1000 || out_status_we !== 1'b0 || out_mem_r_en !== 1'b1
                     || out_wb_en !== 1'b1 || out_dest !== 4'hA || out_br_addr !== 32'hFC) begin
            bad++; $display("FAIL mem_ctrl act=%h/%b/%b/%b/%h/%h exp=1000/0/1/1/a/fc", out_alu_result,
                            out_status_we, out_mem_r_en, out_wb_en, out_dest, out_br_addr); end
        clear_inputs();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain act=%b exp=0", out_valid); end
    endtask

    task automatic test_forwarding();
        set_op(4'b0010, 32'd0, 32'd0, 1'b1, 12'h001);
        sel_src1 = 2; fwd_data = {32'h10, 32'h77};
        step();
        total++; if (out_alu_result !== 32'h11) begin
            bad++; $display("FAIL fwd_src1 act=%h exp=11", out_alu_result); end
        set_op(4'b0010, 32'h100, 32'h55, 1'b0, 12'h000);
        sel_src1 = 0; sel_src2 = 3;
        step();
        total++; if (out_alu_result !== 32'h100 || out_val_rm !== 32'h0) begin
            bad++; $display("FAIL fwd_out_of_range act=%h/%h exp=100/0", out_alu_result, out_val_rm); end
        set_op(4'b0010, 32'h0, 32'h55, 1'b0, 12'h000);
        sel_src2 = 1; mem_w_en = 1;
        step();
        total++; if (out_val_rm !== 32'h77 || out_mem_w_en !== 1'b1) begin
            bad++; $display("FAIL fwd_store_rm act=%h/%b exp=77/1", out_val_rm, out_mem_w_en); end
        clear_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        int errs;
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            set_op(4'b0010, 32'(i * 10), 32'd0, 1'b1, 12'h001);
            step();
            if (out_valid !== 1'b1 || out_alu_result !== 32'(i * 10 + 1)) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL back_to_back act=%0d_errors exp=0", errs); end
        out_ready = 0;
        set_op(4'b0010, 32'd100, 32'd0, 1'b1, 12'h001);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready act=%b exp=0", in_ready); end
        step(); step();
        total++; if (out_valid !== 1'b1 || out_alu_result !== 32'd31) begin
            bad++; $display("FAIL stall_hold act=%b/%h exp=1/1f", out_valid, out_alu_result); end
        out_ready = 1;
        step();
        total++; if (out_valid !== 1'b1 || out_alu_result !== 32'd101) begin
            bad++; $display("FAIL stall_release act=%b/%h exp=1/65", out_valid, out_alu_result); end
        clear_inputs();
        step();
    endtask

    task automatic test_mla();
        int errs;
        errs = 0;
        set_op(4'b1011, 32'd7, 32'd6, 1'b0, 12'h000); val_ra = 32'd4; sr_in = 4'b0010;
        step();
        in_valid = 0; sr_in = 4'b0000;
        for (int i = 0; i < 32; i++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) errs++;
            step();
        end
        total++; if (errs != 0) begin bad++; $display("FAIL mla_busy_window act=%0d_errors exp=0", errs); end
        total++; if (busy !== 1'b0 || out_valid !== 1'b1 || out_alu_result !== 32'd46 || out_status !== 4'b0010) begin
            bad++; $display("FAIL mla_result act=%b/%b/%h/%b exp=0/1/2e/0010", busy, out_valid, out_alu_result, out_status); end
        step();
        set_op(4'b1010, 32'h0001_0000, 32'h0001_0000, 1'b0, 12'h000); sr_in = 4'b0001;
        step();
        in_valid = 0; out_ready = 0;
        for (int i = 0; i < 32; i++) step();
        step(); step();
        total++; if (out_valid !== 1'b1 || out_alu_result !== 32'd0 || out_status !== 4'b0101 || in_ready !== 1'b0) begin
            bad++; $display("FAIL mul_trunc_hold act=%b/%h/%b/%b exp=1/0/0101/0", out_valid, out_alu_result,
                            out_status, in_ready); end
        out_ready = 1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mul_drain act=%b exp=0", out_valid); end
        clear_inputs();
    endtask

    task automatic test_flush();
        int errs;
        errs = 0;
        set_op(4'b1010, 32'd3, 32'd3, 1'b0, 12'h000);
        step();
        in_valid = 0;
        repeat (5) step();
        flush = 1;
        set_op(4'b0010, 32'd1, 32'd0, 1'b1, 12'h001);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready act=%b exp=0", in_ready); end
        step();
        flush = 0; in_valid = 0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_mul act=%b/%b exp=0/0", busy, out_valid); end
        repeat (40) begin
            if (out_valid !== 1'b0) errs++;
            step();
        end
        total++; if (errs != 0) begin bad++; $display("FAIL flush_no_result act=%0d_errors exp=0", errs); end
        set_op(4'b0010, 32'd1, 32'd0, 1'b1, 12'h001); out_ready = 0;
        step();
        in_valid = 0; flush = 1;
        step();
        flush = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_slot act=%b exp=0", out_valid); end
        clear_inputs();
    endtask

    task automatic test_rst_mid();
        int errs;
        errs = 0;
        set_op(4'b0010, 32'd9, 32'd0, 1'b1, 12'h001); out_ready = 0; dest = 4'h3; wb_en = 1;
        step();
        in_valid = 0; rst = 1;
        step();
        rst = 0;
        total++; if (out_valid !== 1'b0 || {out_alu_result, out_dest, out_wb_en} !== '0) begin
            bad++; $display("FAIL rst_slot act=%b/%h/%h/%b exp=0/0/0/0", out_valid, out_alu_result, out_dest, out_wb_en); end
        clear_inputs();
        set_op(4'b1010, 32'd5, 32'd5, 1'b0, 12'h000);
        step();
        in_valid = 0;
        repeat (5) step();
        rst = 1;
        step();
        rst = 0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mul act=%b/%b exp=0/0", busy, out_valid); end
        repeat (40) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) errs++;
            step();
        end
        total++; if (errs != 0) begin bad++; $display("FAIL rst_mul_abort act=%0d_errors exp=0", errs); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_forwarding();
        test_back_to_back();
        test_mla();
        test_flush();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
Parametrised, handshaked ARM execute stage. It contains operand forwarding from N sources, a Val2 generator, a single-cycle ALU, and a new iterative multiplier for MUL/MLA. A registered EXE/MEM output slot makes it stallable between ID/EXE and MEM, with flush support for taken branches.

Parameters:
DATA_W, 32, datapath width; must be ≥ 16 and a multiple of MUL_BPC
FWD_N, 2, number of forwarding sources (MEM-stage ALU result, WB value, ...)
MUL_BPC, 1, multiplier bits retired per cycle (1, 2 or 4); MUL latency = DATA_W/MUL_BPC cycles
DEST_W, 4, destination register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill in-flight op and output slot
in_valid  in  1  ID/EXE op valid
in_ready  out  1  stage accepts op this cycle
exe_cmd  in  4  ALU command (package encoding)
s_bit  in  1  update status flags
mem_r_en, mem_w_en, wb_en  in  1 each  control passthrough
dest  in  DEST_W  write-back register index
pc  in  DATA_W  PC of op
val_rn, val_rm, val_ra  in  DATA_W  register-file operands (val_ra is the MLA accumulator)
imm  in  1  immediate form of operand 2
shift_operand  in  12  ARM shifter operand
signed_imm_24  in  24  branch offset
sr_in  in  4  current {N,Z,C,V}
sel_src1, sel_src2  in  $clog2(FWD_N+1)  0 = register file, k = fwd_data[k-1]
fwd_data  in  FWD_N*DATA_W  forwarding values, source 0 in the LSBs
out_valid  out  1  EXE/MEM slot valid
out_ready  in  1  MEM accepts slot
out_alu_result, out_val_rm, out_br_addr  out  DATA_W each  registered results
out_status  out  4  registered {N,Z,C,V}
out_status_we  out  1  status write enable
out_mem_r_en, out_mem_w_en, out_wb_en  out  1 each  registered control
out_dest  out  DEST_W  registered destination
busy  out  1  multiplier running

Behaviour:
- Reset: every output register = 0; FSM = IDLE; busy = 0; in_ready = 0 during the reset cycle.
- Operand 1 = mux(sel_src1). Rm' = mux(sel_src2). Out-of-range select yields 0.
- Val2 when mem_r_en|mem_w_en: zero-extended shift_operand[11:0].
- Val2 when imm: shift_operand[7:0] rotated right by 2*shift_operand[11:8].
- Val2 otherwise: Rm' shifted by shift_operand[11:7], using type [6:5] = LSL/LSR/ASR/ROR.
- ALU ops: MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR. C and V follow ARM semantics at DATA_W. N = result MSB. Z = result==0. Logical ops leave C and V at sr_in.
- br_addr = pc + sign-extended signed_imm_24, unshifted, at DATA_W.
- out_val_rm = Rm', the forwarded value for stores.
- out_status_we = s_bit & ~mem_r_en & ~mem_w_en.
- in_ready = (state==IDLE) & (~out_valid | out_ready) & ~rst.
- Single-cycle op: accepted when in_valid & in_ready; the slot loads on the next edge (latency 1).
- FSM IDLE -> MUL_RUN on accepting MUL/MLA: capture operand1, Rm', val_ra, control, pc, sr_in. Forwarded operands are sampled only at accept.
- MUL_RUN: counter runs DATA_W/MUL_BPC cycles with shift-add of MUL_BPC bits per cycle; low DATA_W bits are kept.
- MUL_RUN -> IDLE: slot loads if free or draining, else -> MUL_WAIT.
- MUL_WAIT: holds the result; -> IDLE when the slot frees, loading it on that edge.
- MUL/MLA flags: N and Z from the result; C and V = sr_in.
- busy = state != IDLE.
- Slot drains on out_valid & out_ready. If a new load and a drain happen in the same cycle, the load wins and out_valid stays 1.
- Slot holds all values stable while out_valid & ~out_ready.
- flush (priority over everything except rst): out_valid <= 0 and FSM -> IDLE, discarding the multiply. An op presented on the same cycle is not accepted (in_ready forced 0).
- rst during MUL_RUN aborts it exactly as reset does.

Decomposition:
- Package exe_pkg:
  - EXE_CMD encodings: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MUL 1010, MLA 1011.
  - Shift-type encodings.
  - Status bit indices N=3, Z=2, C=1, V=0.
  - FSM state enum.
- Sub-module exe_mul_iter: start, operands, MUL_BPC; produces done and result. It owns the counter and the partial-product accumulator.

Test Plan:
- ADD, val_rn=5, imm=1, shift_operand=0x003, out_ready=1 -> next cycle out_alu_result=8, out_status=0000.
- SUB, val_rn=3, Val2=3, s_bit=1 -> result 0, status N0 Z1 C1 V0; out_status_we=1.
- sel_src1=2 with fwd_data[1]=0x10, ADD with Val2=1 -> 0x11; sel_src2 out of range (FWD_N=2, sel=3) -> Val2 term = 0.
- MLA, 7*6+4, MUL_BPC=1 -> busy 32 cycles, in_ready=0 throughout, result 46. With out_ready held 0 at completion: FSM in MUL_WAIT, result delivered when out_ready rises.
- out_ready=0 with a valid slot -> slot stable, in_ready=0. A back-to-back ADD stream with out_ready=1 -> one result per cycle.
- flush mid-MUL_RUN -> busy=0 next cycle, no out_valid. rst mid-op -> all outputs 0.
